alu_uart_if: RTL and testbench

Byte-sequencing front end that sits directly upstream of `alu` and downstream of the UART receiver/transmitter pair. It collects three received bytes (operand A, operand B, op code) and drives them onto the ALU inputs. It then captures the ALU's combinational result and hands it to the UART transmitter with a single-cycle start pulse. It owns all operand/op-code registers, so the ALU stays purely combinational.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_uart_if_if.sv | 28 ++
 rtl/alu_uart_if_timeout_counter.sv | 26 ++
 rtl/alu_uart_if.sv | 102 ++++++++++
 tb/tb_alu_uart_if.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, default widths and the
// alu_uart_if sequencing FSM encoding.
package alu_pkg;

  localparam int unsigned NB_DATA_DEF        = 8;
  localparam int unsigned NB_CODE_DEF        = 6;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

endpackage

// File: rtl/alu_uart_if_if.sv
// Bundle of UART-side and ALU-side signals around alu_uart_if.
// master = the sequencer, slave = the UART/ALU environment.
interface alu_uart_if_bus #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_CODE = 6
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               tx_done;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic [NB_DATA-1:0] dato1;
  logic [NB_DATA-1:0] dato2;
  logic [NB_CODE-1:0] op_code;
  logic [NB_DATA-1:0] salida;
  logic               busy;
  logic               error;

  modport master (
    input  rx_data, rx_done, tx_done, salida,
    output tx_data, tx_start, dato1, dato2, op_code, busy, error
  );

  modport slave (
    output rx_data, rx_done, tx_done, salida,
    input  tx_data, tx_start, dato1, dato2, op_code, busy, error
  );
endinterface

// File: rtl/alu_uart_if_timeout_counter.sv
// Inter-byte timeout: down-counter reloaded on clear, terminal-count flag
// while enabled at zero. Only instantiated with ALU_UART_IF_TIMEOUT_EN.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= CNT_LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/alu_uart_if.sv
// Byte sequencer between the UART pair and a combinational ALU.
// Optional inter-byte timeout enabled by defining ALU_UART_IF_TIMEOUT_EN.
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA        = NB_DATA_DEF,
  parameter int unsigned NB_CODE        = NB_CODE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alu_uart_if_bus.master bus
);
  state_e             state_q;
  logic [NB_DATA-1:0] dato1_q, dato2_q, tx_data_q;
  logic [NB_CODE-1:0] op_code_q;
  logic               tx_start_q, busy_q, error_q;
  logic               timeout;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("alu_uart_if: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef ALU_UART_IF_TIMEOUT_EN
  logic cnt_en, cnt_clr;

  // Counter holds its load value outside GET_B/GET_OP and restarts per byte.
  assign cnt_en  = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
  assign cnt_clr = !cnt_en || bus.rx_done;

  timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .tc_o  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_GET_A;
      dato1_q    <= '0;
      dato2_q    <= '0;
      op_code_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
      case (state_q)
        ST_GET_A: if (bus.rx_done) begin
          dato1_q <= bus.rx_data;
          state_q <= ST_GET_B;
          busy_q  <= 1'b1;
        end
        ST_GET_B: if (bus.rx_done) begin
          dato2_q <= bus.rx_data;
          state_q <= ST_GET_OP;
        end else if (timeout) begin
          state_q <= ST_GET_A;
          busy_q  <= 1'b0;
          error_q <= 1'b1;
        end
        ST_GET_OP: if (bus.rx_done) begin
          op_code_q <= bus.rx_data[NB_CODE-1:0];
          state_q   <= ST_EXEC;
        end else if (timeout) begin
          state_q <= ST_GET_A;
          busy_q  <= 1'b0;
          error_q <= 1'b1;
        end
        ST_EXEC: begin
          tx_data_q  <= bus.salida;
          tx_start_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: state_q <= ST_WAIT_TX;
        ST_WAIT_TX: if (bus.tx_done) begin
          state_q <= ST_GET_A;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_GET_A;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dato1    = dato1_q;
  assign bus.dato2    = dato2_q;
  assign bus.op_code  = op_code_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.error    = error_q;
endmodule

// File: tb/tb_alu_uart_if.sv
// Directed + randomized bench for alu_uart_if with a behavioural ALU attached.
module tb_alu_uart_if;
  import alu_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_uart_if_bus #(.NB_DATA(8), .NB_CODE(6)) bus ();

  alu_uart_if #(.NB_DATA(8), .NB_CODE(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign bus.salida = alu_ref(bus.dato1, bus.dato2, bus.op_code);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Three back-to-back bytes; returns in SEND after checking the tx_start pulse.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       output logic [7:0] exp_tx);
    exp_tx = alu_ref(a, b, op[5:0]);
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = a;
    @(negedge clk); bus.rx_data = b;
    @(negedge clk); bus.rx_data = op;
    @(negedge clk); bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    check("dato1", 32'(bus.dato1), 32'(a));
    check("dato2", 32'(bus.dato2), 32'(b));
    check("op_code", 32'(bus.op_code), 32'(op[5:0]));
    check("no_start_in_exec", 32'(bus.tx_start), 32'd0);
    check("busy_exec", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("tx_start", 32'(bus.tx_start), 32'd1);
    check("tx_data", 32'(bus.tx_data), 32'(exp_tx));
  endtask

  task automatic finish_tx(input logic [7:0] exp_tx);
    repeat (3) begin
      @(negedge clk);
      check("start_single", 32'(bus.tx_start), 32'd0);
      check("tx_data_hold", 32'(bus.tx_data), 32'(exp_tx));
      check("busy_wait", 32'(bus.busy), 32'd1);
    end
    bus.tx_done = 1'b1;
    @(negedge clk); bus.tx_done = 1'b0;
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_tx;
    logic [7:0] a, b, op;
    logic [5:0] ops [9];
    int errs, err_at;

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, 6'h3F};
    reset = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.tx_done = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_dato1", 32'(bus.dato1), 32'd0);
    check("rst_dato2", 32'(bus.dato2), 32'd0);
    check("rst_op_code", 32'(bus.op_code), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);

    // ADD 5+3
    do_op(8'h05, 8'h03, 8'h20, exp_tx);
    check("add_result", 32'(exp_tx), 32'h08);
    finish_tx(exp_tx);

    // SUB with upper op bits set, then a byte dropped during WAIT_TX
    do_op(8'h03, 8'h05, 8'hE2, exp_tx);
    check("sub_result", 32'(bus.tx_data), 32'hFE);
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = 8'hAA;
    @(negedge clk); bus.rx_done = 1'b0;
    check("drop_dato1", 32'(bus.dato1), 32'h03);
    check("drop_no_start", 32'(bus.tx_start), 32'd0);
    finish_tx(exp_tx);

    do_op(8'h0F, 8'hF0, 8'h27, exp_tx);
    check("nor_result", 32'(bus.tx_data), 32'h00);
    finish_tx(exp_tx);

    // Spurious tx_done in GET_A is ignored
    @(negedge clk); bus.tx_done = 1'b1;
    @(negedge clk); bus.tx_done = 1'b0;
    check("txdone_idle_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom_range(0, 9));
      op = {2'($urandom), ops[$urandom_range(0, 8)]};
      do_op(a, b, op, exp_tx);
      finish_tx(exp_tx);
    end

    // Reset together with the second rx_done
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = 8'h11;
    @(negedge clk); bus.rx_data = 8'h22; reset = 1'b1;
    @(negedge clk); bus.rx_done = 1'b0; reset = 1'b0;
    check("rstrx_dato1", 32'(bus.dato1), 32'd0);
    check("rstrx_dato2", 32'(bus.dato2), 32'd0);
    check("rstrx_busy", 32'(bus.busy), 32'd0);
    do_op(8'h40, 8'h02, 8'h02, exp_tx);
    finish_tx(exp_tx);

    // Reset during SEND kills the pulse
    do_op(8'h21, 8'h12, 8'h26, exp_tx);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rstsend_start", 32'(bus.tx_start), 32'd0);
    check("rstsend_tx_data", 32'(bus.tx_data), 32'd0);
    check("rstsend_busy", 32'(bus.busy), 32'd0);
    check("rstsend_dato1", 32'(bus.dato1), 32'd0);

    // Byte arriving in the last allowed idle cycle is accepted
    errs = 0;
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = 8'h07;
    @(negedge clk); bus.rx_done = 1'b0;
    repeat (TO - 1) begin @(negedge clk); errs += int'(bus.error); end
    bus.rx_done = 1'b1; bus.rx_data = 8'h09;
    @(negedge clk); bus.rx_done = 1'b0; errs += int'(bus.error);
    check("tc_dato2", 32'(bus.dato2), 32'h09);
    check("tc_busy", 32'(bus.busy), 32'd1);
    check("tc_no_error", 32'(errs), 32'd0);
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = 8'h20;
    @(negedge clk); bus.rx_done = 1'b0;
    @(negedge clk);
    check("tc_tx_start", 32'(bus.tx_start), 32'd1);
    check("tc_tx_data", 32'(bus.tx_data), 32'h10);
    finish_tx(8'h10);

    // One byte then silence
    errs = 0; err_at = -1;
    @(negedge clk); bus.rx_done = 1'b1; bus.rx_data = 8'h5A;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk); bus.rx_done = 1'b0;
      if (bus.error === 1'b1) begin
        errs++;
        if (err_at < 0) err_at = i;
      end
    end
    check("to_dato1_kept", 32'(bus.dato1), 32'h5A);
`ifdef ALU_UART_IF_TIMEOUT_EN
    check("to_error_count", 32'(errs), 32'd1);
    check("to_error_cycle", 32'(err_at), 32'(TO + 1));
    check("to_busy", 32'(bus.busy), 32'd0);
`else
    check("to_error_count", 32'(errs), 32'd0);
    check("to_busy", 32'(bus.busy), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
